// File: rtl/completion_arbiter.sv
// completion_arbiter
//   Collects completed requests from four banks into per-bank FIFOs and
//   serialises them onto one completion stream with a round-robin grant.
//
// Ports
//   clk               single clock, all state updates on the rising edge
//   reset             synchronous, active-high
//   bankN_entry [66:0] completed request from bank N ([66:65] CPU id, [64:0] payload)
//   bankN_done        bank N presents a valid entry this cycle
//   bankN_ready       bank N FIFO can accept an entry this cycle (count < FIFO_DEPTH)
//   completed_entry   serialised completion, same layout as bankN_entry (held when idle)
//   completed_ctrl    one-cycle pulse marking completed_entry valid
//   drop_err          sticky: a done arrived while that bank was not ready
module completion_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [66:0] bank0_entry,
    input  logic [66:0] bank1_entry,
    input  logic [66:0] bank2_entry,
    input  logic [66:0] bank3_entry,
    input  logic        bank0_done,
    input  logic        bank1_done,
    input  logic        bank2_done,
    input  logic        bank3_done,
    output logic        bank0_ready,
    output logic        bank1_ready,
    output logic        bank2_ready,
    output logic        bank3_ready,
    output logic [66:0] completed_entry,
    output logic        completed_ctrl,
    output logic        drop_err
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    // Per-bank storage and bookkeeping
    logic [66:0]   mem_q      [4][FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q   [4];
    logic [PW-1:0] wr_ptr_q   [4];
    logic [CW-1:0] count_q    [4];
    logic [1:0]    last_grant_q;
    logic [66:0]   completed_entry_q;
    logic          completed_ctrl_q;
    logic          drop_err_q;

    // Gathered bank inputs
    logic [66:0] entry_w [4];
    logic [3:0]  done_w;
    logic [3:0]  ready_w;
    logic [3:0]  nonempty_w;
    logic [3:0]  push_w;
    logic [3:0]  pop_w;

    // Grant decision
    logic        gnt_valid_d;
    logic [1:0]  gnt_idx_d;
    logic [66:0] head_d;

    assign entry_w[0] = bank0_entry;
    assign entry_w[1] = bank1_entry;
    assign entry_w[2] = bank2_entry;
    assign entry_w[3] = bank3_entry;
    assign done_w     = {bank3_done, bank2_done, bank1_done, bank0_done};

    assign bank0_ready = ready_w[0];
    assign bank1_ready = ready_w[1];
    assign bank2_ready = ready_w[2];
    assign bank3_ready = ready_w[3];

    assign completed_entry = completed_entry_q;
    assign completed_ctrl  = completed_ctrl_q;
    assign drop_err        = drop_err_q;

    // Ready and non-empty come only from the registered counts, so a full
    // FIFO refuses a push even in the cycle it is being popped.
    always_comb begin
        ready_w    = '0;
        nonempty_w = '0;
        push_w     = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            ready_w[n]    = (count_q[n] < CW'(FIFO_DEPTH));
            nonempty_w[n] = (count_q[n] != '0);
            push_w[n]     = done_w[n] & ready_w[n];
        end
    end

    // Round-robin search starting one past the last granted bank; k=4 wraps
    // back onto last_grant itself so it is considered last.
    always_comb begin
        logic [1:0] idx;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = last_grant_q;
        idx         = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last_grant_q + 2'(k);
            if (!gnt_valid_d && nonempty_w[idx]) begin
                gnt_valid_d = 1'b1;
                gnt_idx_d   = idx;
            end
        end
    end

    always_comb begin
        pop_w = '0;
        if (gnt_valid_d) begin
            pop_w[gnt_idx_d] = 1'b1;
        end
        head_d = mem_q[gnt_idx_d][rd_ptr_q[gnt_idx_d]];
    end

    // Storage array is not reset; validity is tracked by the counts alone.
    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < 4; n++) begin
            if (!reset && push_w[n]) begin
                mem_q[n][wr_ptr_q[n]] <= entry_w[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned n = 0; n < 4; n++) begin
                rd_ptr_q[n] <= '0;
                wr_ptr_q[n] <= '0;
                count_q[n]  <= '0;
            end
            last_grant_q      <= 2'd3;
            completed_entry_q <= '0;
            completed_ctrl_q  <= 1'b0;
            drop_err_q        <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (push_w[n]) begin
                    wr_ptr_q[n] <= wr_ptr_q[n] + PW'(1);
                end
                if (pop_w[n]) begin
                    rd_ptr_q[n] <= rd_ptr_q[n] + PW'(1);
                end
                case ({push_w[n], pop_w[n]})
                    2'b10:   count_q[n] <= count_q[n] + CW'(1);
                    2'b01:   count_q[n] <= count_q[n] - CW'(1);
                    default: count_q[n] <= count_q[n];
                endcase
            end

            completed_ctrl_q <= gnt_valid_d;
            if (gnt_valid_d) begin
                completed_entry_q <= head_d;
                last_grant_q      <= gnt_idx_d;
            end

            if (|(done_w & ~ready_w)) begin
                drop_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_completion_arbiter.sv
// tb_completion_arbiter
//   Directed vector table plus hand-written multi-cycle sequences and a
//   random phase, all checked against a queue-based reference model.
module tb_completion_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [66:0] ent [4];
    logic [3:0]  dn;
    logic [3:0]  rdy;
    logic [66:0] c_entry;
    logic        c_ctrl;
    logic        d_err;

    int nvec;
    int nerr;

    // Reference model state
    logic [66:0] mq [4][$];
    int          lg;
    logic        m_ctrl;
    logic [66:0] m_entry;
    logic        m_drop;

    typedef struct {
        bit          rst;
        logic [3:0]  done;
        logic [66:0] base;
        bit          ectrl;
        logic [66:0] eentry;
        logic [3:0]  eready;
        bit          edrop;
    } vec_t;

    vec_t vt [11];

    completion_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (rst),
        .bank0_entry     (ent[0]),
        .bank1_entry     (ent[1]),
        .bank2_entry     (ent[2]),
        .bank3_entry     (ent[3]),
        .bank0_done      (dn[0]),
        .bank1_done      (dn[1]),
        .bank2_done      (dn[2]),
        .bank3_done      (dn[3]),
        .bank0_ready     (rdy[0]),
        .bank1_ready     (rdy[1]),
        .bank2_ready     (rdy[2]),
        .bank3_ready     (rdy[3]),
        .completed_entry (c_entry),
        .completed_ctrl  (c_ctrl),
        .drop_err        (d_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = (mq[b].size() < DEPTH);
        return r;
    endfunction

    // Advance the model with the currently driven inputs, clock once, then
    // compare the DUT outputs against the model just after the edge.
    task automatic tick();
        logic [3:0] r;
        int b;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            lg      = 3;
            m_ctrl  = 1'b0;
            m_entry = '0;
            m_drop  = 1'b0;
        end else begin
            r      = model_ready();
            m_ctrl = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                b = (lg + k) % 4;
                if (!m_ctrl && mq[b].size() > 0) begin
                    m_entry = mq[b].pop_front();
                    m_ctrl  = 1'b1;
                    lg      = b;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (dn[i]) begin
                    if (r[i]) mq[i].push_back(ent[i]);
                    else      m_drop = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("model_ctrl",  67'(c_ctrl), 67'(m_ctrl));
        chk("model_entry", c_entry, m_entry);
        chk("model_ready", 67'(rdy), 67'(model_ready()));
        chk("model_drop",  67'(d_err), 67'(m_drop));
    endtask

    task automatic set_in(input bit r, input logic [3:0] d, input logic [66:0] base);
        rst = r;
        dn  = d;
        for (int i = 0; i < 4; i++) ent[i] = base + 67'(i);
    endtask

    initial begin
        logic [66:0] aa;
        int cnt;
        int pct;
        nvec = 0;
        nerr = 0;
        lg   = 3;
        m_ctrl = 1'b0;
        m_entry = '0;
        m_drop = 1'b0;
        aa = 67'h1_0000_0000_0000_00AA;

        //           rst  done     base      ctrl  entry                     ready    drop
        vt[0]  = '{1'b1, 4'b0000, 67'h0,    1'b0, 67'h0,                    4'hF,    1'b0};
        vt[1]  = '{1'b0, 4'b0001, aa,       1'b0, 67'h0,                    4'hF,    1'b0};
        vt[2]  = '{1'b0, 4'b0000, 67'h0,    1'b1, aa,                       4'hF,    1'b0};
        vt[3]  = '{1'b0, 4'b0000, 67'h0,    1'b0, aa,                       4'hF,    1'b0};
        vt[4]  = '{1'b1, 4'b1111, 67'h55,   1'b0, 67'h0,                    4'hF,    1'b0};
        vt[5]  = '{1'b0, 4'b1111, 67'hA0,   1'b0, 67'h0,                    4'hF,    1'b0};
        vt[6]  = '{1'b0, 4'b0000, 67'h0,    1'b1, 67'hA0,                   4'hF,    1'b0};
        vt[7]  = '{1'b0, 4'b0000, 67'h0,    1'b1, 67'hA1,                   4'hF,    1'b0};
        vt[8]  = '{1'b0, 4'b0000, 67'h0,    1'b1, 67'hA2,                   4'hF,    1'b0};
        vt[9]  = '{1'b0, 4'b0000, 67'h0,    1'b1, 67'hA3,                   4'hF,    1'b0};
        vt[10] = '{1'b0, 4'b0000, 67'h0,    1'b0, 67'hA3,                   4'hF,    1'b0};

        set_in(1'b1, 4'b0000, 67'h0);
        tick();

        for (int v = 0; v < 11; v++) begin
            set_in(vt[v].rst, vt[v].done, vt[v].base);
            tick();
            chk($sformatf("vec%0d_ctrl", v),  67'(c_ctrl), 67'(vt[v].ectrl));
            chk($sformatf("vec%0d_entry", v), c_entry, vt[v].eentry);
            chk($sformatf("vec%0d_ready", v), 67'(rdy), 67'(vt[v].eready));
            chk($sformatf("vec%0d_drop", v),  67'(d_err), 67'(vt[v].edrop));
        end

        // Bank2 streaming, bank0 one entry: grants must go 2,0,2,2
        set_in(1'b1, 4'b0000, 67'h0); tick();
        set_in(1'b0, 4'b0100, 67'h0); ent[2] = 67'hB20; tick();
        chk("rr_first_ctrl", 67'(c_ctrl), 67'h0);
        dn = 4'b0101; ent[2] = 67'hB21; ent[0] = 67'hB00; tick();
        chk("rr_g2a", c_entry, 67'hB20);
        dn = 4'b0100; ent[2] = 67'hB22; tick();
        chk("rr_g0", c_entry, 67'hB00);
        dn = 4'b0000; tick();
        chk("rr_g2b", c_entry, 67'hB21);
        tick();
        chk("rr_g2c", c_entry, 67'hB22);
        tick();
        chk("rr_idle_ctrl", 67'(c_ctrl), 67'h0);

        // Fill bank1 while every bank competes, then overflow it
        set_in(1'b1, 4'b0000, 67'h0); tick();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (mq[1].size() == DEPTH) break;
            dn = model_ready();
            for (int i = 0; i < 4; i++) ent[i] = {2'(i), 65'(32'hC000 + cnt * 4 + i)};
            cnt++;
            tick();
        end
        chk("full_b1_ready", 67'(rdy[1]), 67'h0);
        chk("full_drop_clear", 67'(d_err), 67'h0);
        dn = 4'b0010; ent[1] = 67'h1_DEAD; tick();
        chk("overflow_drop", 67'(d_err), 67'h1);
        dn = 4'b0000;
        for (int c = 0; c < 20; c++) tick();
        chk("drain_b1_ready", 67'(rdy[1]), 67'h1);
        chk("drop_sticky", 67'(d_err), 67'h1);
        chk("drain_idle", 67'(c_ctrl), 67'h0);

        // Reset with bank3 holding three entries
        set_in(1'b1, 4'b0000, 67'h0); tick();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b0, 4'b1111, 67'hD00 + 67'(c * 16));
            tick();
        end
        set_in(1'b1, 4'b0001, 67'h0); ent[0] = 67'hEEE; tick();
        chk("rst_ctrl", 67'(c_ctrl), 67'h0);
        chk("rst_drop", 67'(d_err), 67'h0);
        chk("rst_ready", 67'(rdy), 67'hF);
        chk("rst_entry", c_entry, 67'h0);
        set_in(1'b0, 4'b0000, 67'h0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("post_rst_no_stale", 67'(c_ctrl), 67'h0);
        end

        // Random traffic, alternating light and heavy load
        set_in(1'b1, 4'b0000, 67'h0); tick();
        rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            pct = ((c / 500) % 2 == 1) ? 40 : 15;
            for (int i = 0; i < 4; i++) begin
                dn[i]  = ($urandom_range(0, 99) < pct);
                ent[i] = 67'({$urandom, $urandom, $urandom});
            end
            tick();
        end
        dn = 4'b0000;
        for (int c = 0; c < 4 * DEPTH + 4; c++) tick();
        chk("final_drained_ctrl", 67'(c_ctrl), 67'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/completion_arbiter.md
COMPLETION_ARBITER -- requirements
Module: completion_arbiter

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4, SHALL set the per-bank completion FIFO depth in entries (power of two, 2..16).
- REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: bankN_entry  input  67  completed request from bank N (N=0..3); [66:65] CPU id, [64:0] response payload.
- REQ-005: bankN_done  input  1  bank N presents a valid completed entry this cycle.
- REQ-006: bankN_ready  output  1  bank N FIFO can accept an entry this cycle.
- REQ-007: completed_entry  output  67  serialized completion entry, same field layout as bankN_entry.
- REQ-008: completed_ctrl  output  1  completed_entry is valid this cycle (one-cycle pulse per entry).
- REQ-009: drop_err  output  1  sticky flag; some bankN_done arrived while bankN_ready was 0.

Function
- REQ-010: Each bank SHALL own a FIFO_DEPTH-entry FIFO with a read pointer, a write pointer and an occupancy count of width clog2(FIFO_DEPTH)+1.
- REQ-011: bankN_ready SHALL equal (countN < FIFO_DEPTH), derived only from registered count.
- REQ-012: A push SHALL occur at a rising edge when bankN_done=1 and bankN_ready=1; all 67 bits SHALL be stored unmodified.
- REQ-013: bankN_done=1 with bankN_ready=0 SHALL discard the entry, leave FIFO N unchanged and set drop_err to 1.
- REQ-014: A full FIFO SHALL NOT accept a push in the same cycle it is popped; ready depends only on the start-of-cycle count.
- REQ-015: Each cycle the arbiter SHALL examine the non-empty flags at the start of the cycle and grant at most one bank.
- REQ-016: Grant SHALL be round-robin: search order starts at bank (last_grant+1) mod 4 and wraps.
- REQ-017: After reset the search order SHALL start at bank 0; last_grant SHALL change only on a grant.
- REQ-018: On a grant, the head of the granted FIFO SHALL be popped and registered into completed_entry at that rising edge. completed_ctrl SHALL be 1 for exactly the following cycle.
- REQ-019: A cycle with no non-empty FIFO SHALL produce completed_ctrl=0 in the next cycle, and completed_entry SHALL hold its previous value.
- REQ-020: There SHALL be no bypass. An entry pushed at edge E can be granted no earlier than the cycle after E and appears with completed_ctrl=1 no earlier than the cycle after edge E+1.
- REQ-021: A simultaneous push and pop on the same non-full FIFO SHALL both take effect; the count SHALL stay unchanged.
- REQ-022: Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL never exceed FIFO_DEPTH or go below 0.
- REQ-023: Per-bank ordering SHALL be preserved (FIFO order). Cross-bank order is set only by the round-robin grant.
- REQ-024: Sustained throughput SHALL be one completion per cycle whenever any FIFO is non-empty; there is no downstream backpressure.

Reset
- REQ-025: While reset=1 at a rising edge, all counts and pointers SHALL become 0, last_grant SHALL become 3 so the next search starts at bank 0, and completed_ctrl, completed_entry and drop_err SHALL become 0.
- REQ-026: Entries held when reset is asserted mid-operation SHALL be discarded. bankN_done during a reset cycle SHALL be ignored and SHALL NOT set drop_err.
- REQ-027: In the first cycle after reset deasserts, bankN_ready SHALL be 1 for all N and completed_ctrl SHALL be 0.

Verification
- REQ-028: Push 67'h1_0000_0000_0000_00AA on bank0 at one edge only -> completed_ctrl=1 with that value exactly one cycle later than the earliest legal grant (REQ-020), then 0.
- REQ-029: All four banks push in the same cycle (entry values 0xA0..0xA3) -> outputs appear on four consecutive cycles in bank order 0,1,2,3.
- REQ-030: Bank2 pushes continuously while bank0 pushes one entry -> bank0's entry appears within 2 grants, and grants alternate 2,0,2.
- REQ-031: Fill bank1 with FIFO_DEPTH=4 entries while no grant drains it -> bank1_ready=0; a 5th done sets drop_err=1. The 4 stored entries then emerge in order and bank1_ready returns to 1.
- REQ-032: Assert reset with 3 entries queued in bank3 -> completed_ctrl=0, drop_err=0, all ready=1, and no stale entry is ever output afterwards.
- REQ-033: Random pushes over 10,000 cycles against a scoreboard -> every accepted entry is output exactly once, in per-bank order, with no idle output cycle while any FIFO is non-empty.
